// File: rtl/matrix_mult_mnp.sv
// Signed M x N by N x P matrix multiplier: one MAC per cycle, results streamed
// row-major over a valid/ready handshake, with optional transposed B operand.
module matrix_mult_mnp #(
    parameter int unsigned M          = 3,
    parameter int unsigned N          = 3,
    parameter int unsigned P          = 3,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ACC_WIDTH  = 66,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic                                   transpose_b,
    input  logic                                   abort,
    input  logic [DATA_WIDTH-1:0]                  a_in,
    input  logic [ADDR_WIDTH-1:0]                  a_addr,
    input  logic                                   a_wen,
    input  logic [DATA_WIDTH-1:0]                  b_in,
    input  logic [ADDR_WIDTH-1:0]                  b_addr,
    input  logic                                   b_wen,
    output logic [ACC_WIDTH-1:0]                   c_out,
    output logic [((M > 1) ? $clog2(M) : 1)-1:0]   c_row,
    output logic [((P > 1) ? $clog2(P) : 1)-1:0]   c_col,
    output logic                                   c_valid,
    input  logic                                   c_ready,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   wr_err
);

    localparam int unsigned ROW_W = (M > 1) ? $clog2(M) : 1;
    localparam int unsigned COL_W = (P > 1) ? $clog2(P) : 1;
    localparam int unsigned K_W   = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] A_SIZE = (ADDR_WIDTH + 1)'(M * N);
    localparam logic [ADDR_WIDTH:0] B_SIZE = (ADDR_WIDTH + 1)'(N * P);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_OUT, S_DONE} state_t;

    state_t                 state_q, state_d;
    logic [ROW_W-1:0]       i_q, i_d;
    logic [COL_W-1:0]       j_q, j_d;
    logic [K_W-1:0]         k_q, k_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic                   xpose_q, xpose_d;
    logic [ACC_WIDTH-1:0]   c_out_q, c_out_d;
    logic [ROW_W-1:0]       c_row_q, c_row_d;
    logic [COL_W-1:0]       c_col_q, c_col_d;
    logic                   c_valid_q, c_valid_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   wr_err_q, wr_err_d;

    logic [DATA_WIDTH-1:0]  a_mem [DEPTH];
    logic [DATA_WIDTH-1:0]  b_mem [DEPTH];

    logic                   wr_open, a_we, b_we;
    logic [ADDR_WIDTH-1:0]  a_ra, b_ra;
    logic signed [ACC_WIDTH-1:0] prod;
    logic [ACC_WIDTH-1:0]   sum;

    // Operand writes are only accepted while no computation is reading the files
    assign wr_open  = (state_q == S_IDLE) || (state_q == S_DONE);
    assign a_we     = a_wen && wr_open && ({1'b0, a_addr} < A_SIZE);
    assign b_we     = b_wen && wr_open && ({1'b0, b_addr} < B_SIZE);
    assign wr_err_d = (a_wen && !a_we) || (b_wen && !b_we);

    always_ff @(posedge clk) begin
        if (a_we) a_mem[a_addr] <= a_in;
        if (b_we) b_mem[b_addr] <= b_in;
    end

    assign a_ra = ADDR_WIDTH'(32'(i_q) * N + 32'(k_q));
    assign b_ra = xpose_q ? ADDR_WIDTH'(32'(j_q) * N + 32'(k_q))
                          : ADDR_WIDTH'(32'(k_q) * P + 32'(j_q));
    // Both operands sign-extended before the multiply so the product is exact
    assign prod = ACC_WIDTH'($signed(a_mem[a_ra])) * ACC_WIDTH'($signed(b_mem[b_ra]));
    assign sum  = acc_q + prod;

    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        k_d       = k_q;
        acc_d     = acc_q;
        xpose_d   = xpose_q;
        c_out_d   = c_out_q;
        c_row_d   = c_row_q;
        c_col_d   = c_col_q;
        c_valid_d = c_valid_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                    acc_d   = '0;
                    xpose_d = transpose_b;
                    busy_d  = 1'b1;
                end
            end
            S_RUN: begin
                acc_d = sum;
                if (k_q == K_W'(N - 1)) begin
                    c_out_d   = sum;
                    c_row_d   = i_q;
                    c_col_d   = j_q;
                    c_valid_d = 1'b1;
                    state_d   = S_OUT;
                end else begin
                    k_d = k_q + K_W'(1);
                end
            end
            S_OUT: begin
                if (c_ready) begin
                    c_valid_d = 1'b0;
                    acc_d     = '0;
                    k_d       = '0;
                    if (j_q < COL_W'(P - 1)) begin
                        j_d     = j_q + COL_W'(1);
                        state_d = S_RUN;
                    end else if (i_q < ROW_W'(M - 1)) begin
                        i_d     = i_q + ROW_W'(1);
                        j_d     = '0;
                        state_d = S_RUN;
                    end else begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Abort only cancels active work; a completed operation still reports done
        if (abort && ((state_q == S_RUN) || (state_q == S_OUT))) begin
            state_d   = S_IDLE;
            c_valid_d = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            i_q       <= '0;
            j_q       <= '0;
            k_q       <= '0;
            acc_q     <= '0;
            xpose_q   <= 1'b0;
            c_out_q   <= '0;
            c_row_q   <= '0;
            c_col_q   <= '0;
            c_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wr_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            j_q       <= j_d;
            k_q       <= k_d;
            acc_q     <= acc_d;
            xpose_q   <= xpose_d;
            c_out_q   <= c_out_d;
            c_row_q   <= c_row_d;
            c_col_q   <= c_col_d;
            c_valid_q <= c_valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            wr_err_q  <= wr_err_d;
        end
    end

    assign c_out   = c_out_q;
    assign c_row   = c_row_q;
    assign c_col   = c_col_q;
    assign c_valid = c_valid_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign wr_err  = wr_err_q;

endmodule

// File: tb/tb_matrix_mult_mnp.sv
// Scoreboard bench for matrix_mult_mnp: a 3x3x3 instance for the main scenarios
// and a 2x4x3 instance for the non-square shape.
module tb_matrix_mult_mnp;

    typedef struct {
        logic [65:0] v;
        int          r;
        int          c;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        start = 1'b0, transpose_b = 1'b0, abort = 1'b0;
    logic [31:0] a_in = '0, b_in = '0;
    logic [3:0]  a_addr = '0, b_addr = '0;
    logic        a_wen = 1'b0, b_wen = 1'b0;
    logic [65:0] c_out;
    logic [1:0]  c_row, c_col;
    logic        c_valid, busy, done, wr_err;
    logic        c_ready = 1'b1;

    logic        s_start = 1'b0;
    logic [31:0] s_a_in = '0, s_b_in = '0;
    logic [3:0]  s_a_addr = '0, s_b_addr = '0;
    logic        s_a_wen = 1'b0, s_b_wen = 1'b0;
    logic [65:0] s_c_out;
    logic [0:0]  s_c_row;
    logic [1:0]  s_c_col;
    logic        s_c_valid, s_busy, s_done, s_wr_err;
    logic        s_c_ready = 1'b1;

    matrix_mult_mnp dut (
        .clk(clk), .rst(rst), .start(start), .transpose_b(transpose_b), .abort(abort),
        .a_in(a_in), .a_addr(a_addr), .a_wen(a_wen),
        .b_in(b_in), .b_addr(b_addr), .b_wen(b_wen),
        .c_out(c_out), .c_row(c_row), .c_col(c_col), .c_valid(c_valid), .c_ready(c_ready),
        .busy(busy), .done(done), .wr_err(wr_err)
    );

    matrix_mult_mnp #(.M(2), .N(4), .P(3)) dut_s (
        .clk(clk), .rst(rst), .start(s_start), .transpose_b(1'b0), .abort(1'b0),
        .a_in(s_a_in), .a_addr(s_a_addr), .a_wen(s_a_wen),
        .b_in(s_b_in), .b_addr(s_b_addr), .b_wen(s_b_wen),
        .c_out(s_c_out), .c_row(s_c_row), .c_col(s_c_col), .c_valid(s_c_valid), .c_ready(s_c_ready),
        .busy(s_busy), .done(s_done), .wr_err(s_wr_err)
    );

    int   n_checks = 0;
    int   n_fail = 0;
    int   stall_cnt = 0;
    exp_t q0[$];
    exp_t q1[$];

    task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor for the 3x3x3 instance: scoreboard pops and hold-stability while stalled
    logic        held = 1'b0;
    logic [65:0] h_out;
    logic [1:0]  h_row, h_col;
    always @(negedge clk) begin
        exp_t e;
        if (rst || !c_valid) begin
            held = 1'b0;
        end else if (!c_ready) begin
            stall_cnt++;
            if (held) begin
                check("hold_c_out", c_out, h_out);
                check("hold_c_row", 66'(c_row), 66'(h_row));
                check("hold_c_col", 66'(c_col), 66'(h_col));
            end
            h_out = c_out;
            h_row = c_row;
            h_col = c_col;
            held  = 1'b1;
        end else begin
            held = 1'b0;
            if (q0.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL extra_elem: got element (%0d,%0d) expected none", c_row, c_col);
            end else begin
                e = q0.pop_front();
                check("c_out", c_out, e.v);
                check("c_row", 66'(c_row), 66'(e.r));
                check("c_col", 66'(c_col), 66'(e.c));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && s_c_valid && s_c_ready) begin
            if (q1.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL s_extra_elem: got element (%0d,%0d) expected none", s_c_row, s_c_col);
            end else begin
                e = q1.pop_front();
                check("s_c_out", s_c_out, e.v);
                check("s_c_row", 66'(s_c_row), 66'(e.r));
                check("s_c_col", 66'(s_c_col), 66'(e.c));
            end
        end
    end

    task automatic push9(input int v[9]);
        exp_t e;
        for (int n = 0; n < 9; n++) begin
            e.v = 66'(v[n]);
            e.r = n / 3;
            e.c = n % 3;
            q0.push_back(e);
        end
    endtask

    task automatic wr(input bit is_b, input int addr, input int val, input bit exp_err);
        if (is_b) begin
            b_wen = 1'b1; b_addr = 4'(addr); b_in = 32'(val);
        end else begin
            a_wen = 1'b1; a_addr = 4'(addr); a_in = 32'(val);
        end
        @(posedge clk); #1;
        a_wen = 1'b0;
        b_wen = 1'b0;
        @(negedge clk);
        check("wr_err", 66'(wr_err), 66'(exp_err));
        @(posedge clk); #1;
    endtask

    task automatic load(input bit is_b, input int v[9]);
        for (int n = 0; n < 9; n++) wr(is_b, n, v[n], 1'b0);
    endtask

    // ready_mode: 0 always ready, 1 random, 2 never ready
    task automatic run_op(input bit tp, input int ready_mode, input int abort_cyc,
                          input int rst_cyc, input int wr_cyc);
        int cyc;
        int stop;
        bit seen_done;
        bit expect_done;
        expect_done = (abort_cyc == 0) && (rst_cyc == 0);
        stop        = (abort_cyc > 0) ? abort_cyc : rst_cyc;
        seen_done   = 1'b0;
        stall_cnt   = 0;
        transpose_b = tp;
        start       = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc   = 1;
        while (1) begin
            c_ready = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            abort   = (cyc == abort_cyc);
            rst     = (cyc == rst_cyc);
            a_wen   = (cyc == wr_cyc);
            a_addr  = 4'd0;
            a_in    = 32'd99;
            @(negedge clk);
            if (cyc == 1) check("busy_rise", 66'(busy), 66'(1));
            if (cyc == 4) check("first_valid", 66'(c_valid), 66'(1));
            if (wr_cyc > 0 && cyc == wr_cyc + 1) check("wr_err_busy", 66'(wr_err), 66'(1));
            if (wr_cyc > 0 && cyc == wr_cyc + 2) check("wr_err_clear", 66'(wr_err), 66'(0));
            if (stop > 0 && cyc == stop + 1) begin
                check("stop_busy", 66'(busy), 66'(0));
                check("stop_valid", 66'(c_valid), 66'(0));
                if (rst_cyc > 0) begin
                    check("rst_c_out", c_out, 66'(0));
                    check("rst_c_row", 66'(c_row), 66'(0));
                    check("rst_c_col", 66'(c_col), 66'(0));
                    check("rst_done", 66'(done), 66'(0));
                    check("rst_wr_err", 66'(wr_err), 66'(0));
                end
            end
            if (done) seen_done = 1'b1;
            if (expect_done && done) begin
                check("done_cycle", 66'(cyc), 66'(37 + stall_cnt));
                check("busy_fall", 66'(busy), 66'(0));
                check("queue_empty", 66'(q0.size()), 66'(0));
                break;
            end
            if (!expect_done && cyc == stop + 12) begin
                check("no_done", 66'(seen_done), 66'(0));
                check("abort_queue", 66'(q0.size()), 66'(0));
                break;
            end
            if (cyc >= 600) begin
                n_checks++;
                n_fail++;
                $display("FAIL run_timeout: got no done after %0d cycles expected done", cyc);
                break;
            end
            @(posedge clk); #1;
            cyc++;
        end
        if (expect_done && seen_done) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("done_pulse", 66'(done), 66'(0));
        end
        @(posedge clk); #1;
        c_ready = 1'b1;
        abort   = 1'b0;
        rst     = 1'b0;
        a_wen   = 1'b0;
        q0.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int eye[9], seq[9], m2[9], bt[9];
        int sa[8], sb[12], sc[6];
        exp_t e;
        int cyc;
        eye = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
        seq = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        m2  = '{-2, -2, -2, -2, -2, -2, -2, -2, -2};
        bt  = '{1, 1, 1, 2, 2, 2, 3, 3, 3};

        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_c_out", c_out, 66'(0));
        check("rst_c_row", 66'(c_row), 66'(0));
        check("rst_c_col", 66'(c_col), 66'(0));
        check("rst_c_valid", 66'(c_valid), 66'(0));
        check("rst_busy", 66'(busy), 66'(0));
        check("rst_done", 66'(done), 66'(0));
        check("rst_wr_err", 66'(wr_err), 66'(0));
        @(posedge clk); #1;
        rst = 1'b0;

        // Identity, plus rejected writes (out of range, and while busy at cycle 5)
        load(1'b0, eye);
        load(1'b1, seq);
        wr(1'b0, 9, 77, 1'b1);
        wr(1'b1, 15, 77, 1'b1);
        push9(seq);
        run_op(1'b0, 0, 0, 0, 5);

        // Backpressure on the same operands; A[0] must still be 1
        push9(seq);
        run_op(1'b0, 1, 0, 0, 0);

        // All -2 times transposed B (B[k][j] = j+1)
        load(1'b0, m2);
        load(1'b1, bt);
        push9('{-6, -12, -18, -6, -12, -18, -6, -12, -18});
        run_op(1'b1, 0, 0, 0, 0);

        // All -2 times row-major [1..9]: column sums 12, 15, 18
        load(1'b1, seq);
        push9('{-24, -30, -36, -24, -30, -36, -24, -30, -36});
        run_op(1'b0, 0, 0, 0, 0);

        // Most negative operands: 3 * 2^62 must not wrap
        for (int n = 0; n < 9; n++) begin
            wr(1'b0, n, 32'h8000_0000, 1'b0);
            wr(1'b1, n, 32'h8000_0000, 1'b0);
        end
        for (int n = 0; n < 9; n++) begin
            e.v = 66'd3 << 62;
            e.r = n / 3;
            e.c = n % 3;
            q0.push_back(e);
        end
        run_op(1'b0, 0, 0, 0, 0);

        // Abort during RUN of element (1,1): only (0,0)..(1,0) emerge
        load(1'b0, eye);
        load(1'b1, seq);
        for (int n = 0; n < 4; n++) begin
            e.v = 66'(n + 1);
            e.r = n / 3;
            e.c = n % 3;
            q0.push_back(e);
        end
        run_op(1'b0, 0, 17, 0, 0);

        // Reset while stalled in OUT, then a clean rerun
        run_op(1'b0, 2, 0, 5, 0);
        push9(seq);
        run_op(1'b0, 0, 0, 0, 0);

        // 2x4x3 shape
        sa = '{1, 2, 3, 4, -1, 0, 2, -3};
        sb = '{1, 0, 2, -1, 3, 1, 2, 2, -2, 0, 1, 4};
        sc = '{5, 16, 14, 3, 1, -18};
        for (int n = 0; n < 12; n++) begin
            s_a_wen  = (n < 8);
            s_a_addr = 4'(n);
            s_a_in   = 32'(sa[n % 8]);
            s_b_wen  = 1'b1;
            s_b_addr = 4'(n);
            s_b_in   = 32'(sb[n]);
            @(posedge clk); #1;
        end
        s_a_wen = 1'b0;
        s_b_wen = 1'b0;
        for (int n = 0; n < 6; n++) begin
            e.v = 66'(sc[n]);
            e.r = n / 3;
            e.c = n % 3;
            q1.push_back(e);
        end
        s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        cyc = 1;
        while (1) begin
            @(negedge clk);
            if (s_done) begin
                check("s_done_cycle", 66'(cyc), 66'(31));
                check("s_queue_empty", 66'(q1.size()), 66'(0));
                check("s_busy_fall", 66'(s_busy), 66'(0));
                check("s_wr_err", 66'(s_wr_err), 66'(0));
                break;
            end
            if (cyc >= 200) begin
                n_checks++;
                n_fail++;
                $display("FAIL s_timeout: got no done after %0d cycles expected done", cyc);
                break;
            end
            @(posedge clk); #1;
            cyc++;
        end
        @(posedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
